// File: rtl/ecrc_pkg.sv
// Shared definitions for the ECRC sequencing controller: FSM encoding, CRC seed
// and the per-byte bit-reversal applied to the transmitted ECRC.
package ecrc_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCUM  = 2'd1;
   localparam logic [1:0] ST_PASS   = 2'd2;
   localparam logic [1:0] ST_APPEND = 2'd3;

   localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

   function automatic logic [31:0] byte_bitrev(input logic [31:0] v);
      logic [31:0] r;
      r = '0;
      for (int unsigned b = 0; b < 4; b++) begin
         for (int unsigned k = 0; k < 8; k++) begin
            r[8*b + k] = v[8*b + 7 - k];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/ecrc_seq_ctrl_if.sv
// Beat, CRC-engine and ECRC handshake signals of the ECRC sequencing controller.
// slave = controller view, master = surrounding datapath / engine view.
interface ecrc_seq_ctrl_if #(
   parameter int DATA_WIDTH   = 256,
   parameter int LENGTH_WIDTH = 4,
   parameter int POLY_WIDTH   = 32
) ();

   logic                    i_valid;
   logic                    o_ready;
   logic                    i_sop;
   logic                    i_eop;
   logic                    i_td;
   logic [DATA_WIDTH-1:0]   i_data;
   logic [LENGTH_WIDTH-1:0] i_len;
   logic [DATA_WIDTH-1:0]   o_crc_msg;
   logic [LENGTH_WIDTH-1:0] o_crc_len;
   logic                    o_crc_en;
   logic [POLY_WIDTH-1:0]   o_crc_seed;
   logic                    o_crc_seed_load;
   logic [POLY_WIDTH-1:0]   i_crc;
   logic                    o_ecrc_valid;
   logic                    i_ecrc_ready;
   logic [POLY_WIDTH-1:0]   o_ecrc;
   logic                    o_err;

   modport slave (
      input  i_valid, i_sop, i_eop, i_td, i_data, i_len, i_crc, i_ecrc_ready,
      output o_ready, o_crc_msg, o_crc_len, o_crc_en, o_crc_seed, o_crc_seed_load,
             o_ecrc_valid, o_ecrc, o_err
   );

   modport master (
      output i_valid, i_sop, i_eop, i_td, i_data, i_len, i_crc, i_ecrc_ready,
      input  o_ready, o_crc_msg, o_crc_len, o_crc_en, o_crc_seed, o_crc_seed_load,
             o_ecrc_valid, o_ecrc, o_err
   );

endinterface

// File: rtl/ecrc_out_reg.sv
// Holding register for the finished ECRC; loaded on entry to APPEND, cleared when
// the framer takes it, so the value is stable while valid and not ready.
module ecrc_out_reg #(
   parameter int POLY_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_i,
   input  logic [POLY_WIDTH-1:0] ecrc_i,
   input  logic                  take_i,
   output logic [POLY_WIDTH-1:0] ecrc_o,
   output logic                  valid_o
);

   logic [POLY_WIDTH-1:0] ecrc_q;
   logic                  valid_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ecrc_q  <= '0;
         valid_q <= 1'b0;
      end else if (load_i) begin
         ecrc_q  <= ecrc_i;
         valid_q <= 1'b1;
      end else if (valid_q && take_i) begin
         ecrc_q  <= '0;
         valid_q <= 1'b0;
      end
   end

   assign ecrc_o  = ecrc_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/ecrc_seq_ctrl.sv
// Sequences an external combinational CRC32 engine over the beats of one TLP and
// hands the final ECRC to the framer. Optional macro: ECRC_VARIANT_MASK_EN.
module ecrc_seq_ctrl
   import ecrc_pkg::*;
#(
   parameter int DATA_WIDTH   = 256,
   parameter int LENGTH_WIDTH = 4,
   parameter int POLY_WIDTH   = 32
) (
   input logic             clk,
   input logic             rst_n,
   ecrc_seq_ctrl_if.slave  bus
);

   localparam int unsigned MAX_DW = DATA_WIDTH / 32;

   logic [1:0]            state_q, state_d;
   logic [POLY_WIDTH-1:0] crc_q, crc_d;
   logic                  err_q, err_d;
   logic                  accept, in_tlp, beat_ok, td_eff, len_ok, crc_en, load_ecrc;
   logic [DATA_WIDTH-1:0] msg;

   assign bus.o_ready = (state_q != ST_APPEND);
   assign accept      = bus.i_valid & bus.o_ready;
   assign in_tlp      = (state_q == ST_ACCUM) || (state_q == ST_PASS);
   assign beat_ok     = accept & (bus.i_sop | in_tlp);
   assign td_eff      = bus.i_sop ? bus.i_td : (state_q == ST_ACCUM);
   assign len_ok      = (bus.i_len != '0) && (32'(bus.i_len) <= MAX_DW);
   assign crc_en      = rst_n & beat_ok & td_eff & len_ok;

`ifdef ECRC_VARIANT_MASK_EN
   // Type[0] and EP are hashed as 1 so the ECRC is independent of them.
   always_comb begin
      msg = bus.i_data;
      if (bus.i_sop) begin
         msg[DATA_WIDTH-8]  = 1'b1;
         msg[DATA_WIDTH-18] = 1'b1;
      end
   end
`else
   assign msg = bus.i_data;
`endif

   assign bus.o_crc_msg       = msg;
   assign bus.o_crc_len       = bus.i_len;
   assign bus.o_crc_en        = crc_en;
   assign bus.o_crc_seed_load = rst_n & accept & bus.i_sop;
   assign bus.o_crc_seed      = bus.i_sop ? CRC_INIT : crc_q;

   always_comb begin
      state_d = state_q;
      crc_d   = crc_q;
      err_d   = 1'b0;
      if (accept) begin
         if (bus.i_sop) begin
            // a SOP always restarts, aborting any TLP in flight
            crc_d = CRC_INIT;
            if (in_tlp) err_d = 1'b1;
            if (bus.i_td) state_d = bus.i_eop ? ST_APPEND : ST_ACCUM;
            else          state_d = bus.i_eop ? ST_IDLE   : ST_PASS;
         end else if (in_tlp) begin
            if (bus.i_eop) state_d = (state_q == ST_ACCUM) ? ST_APPEND : ST_IDLE;
         end else begin
            err_d = 1'b1;
         end
         if (beat_ok && !len_ok) err_d = 1'b1;
         if (crc_en) crc_d = bus.i_crc;
      end else if ((state_q == ST_APPEND) && bus.i_ecrc_ready) begin
         state_d = ST_IDLE;
         crc_d   = CRC_INIT;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         crc_q   <= CRC_INIT;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         err_q   <= err_d;
      end
   end

   assign load_ecrc = accept & (state_d == ST_APPEND);
   assign bus.o_err = err_q;

   ecrc_out_reg #(.POLY_WIDTH(POLY_WIDTH)) u_out (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load_ecrc),
      .ecrc_i  (~byte_bitrev(crc_d)),
      .take_i  (bus.i_ecrc_ready),
      .ecrc_o  (bus.o_ecrc),
      .valid_o (bus.o_ecrc_valid)
   );

endmodule

// File: tb/tb_ecrc_seq_ctrl.sv
// Directed bench for ecrc_seq_ctrl with a bit-serial CRC32 engine model feeding i_crc.
module tb_ecrc_seq_ctrl;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   logic [255:0] d0, d1, d2, d3, d4, dm;
   logic [31:0]  e, e1, e2;

   ecrc_seq_ctrl_if #(.DATA_WIDTH(256), .LENGTH_WIDTH(4), .POLY_WIDTH(32)) bus ();

   ecrc_seq_ctrl #(.DATA_WIDTH(256), .LENGTH_WIDTH(4), .POLY_WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] crc_step(input logic [31:0] seed, input logic [255:0] msg,
                                            input int unsigned ndw);
      logic [31:0] c;
      logic        fb;
      int unsigned n;
      c = seed;
      n = (ndw > 8) ? 8 : ndw;
      for (int unsigned i = 0; i < n * 32; i++) begin
         fb = c[31] ^ msg[255 - i];
         c  = {c[30:0], 1'b0};
         if (fb) c = c ^ 32'h04C1_1DB7;
      end
      return c;
   endfunction

   function automatic logic [31:0] fin(input logic [31:0] c);
      logic [31:0] r;
      for (int unsigned i = 0; i < 32; i++) r[i] = c[(i / 8) * 8 + 7 - (i % 8)];
      return ~r;
   endfunction

   function automatic logic [255:0] sopmsg(input logic [255:0] d);
      logic [255:0] m;
      m = d;
`ifdef ECRC_VARIANT_MASK_EN
      m[248] = 1'b1;
      m[238] = 1'b1;
`endif
      return m;
   endfunction

   // combinational engine stand-in
   always_comb bus.i_crc = crc_step(bus.o_crc_seed, bus.o_crc_msg, 32'(bus.o_crc_len));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic sop, input logic eop, input logic td, input logic [3:0] len,
                       input logic [255:0] data);
      bus.i_valid = 1'b1;
      bus.i_sop   = sop;
      bus.i_eop   = eop;
      bus.i_td    = td;
      bus.i_len   = len;
      bus.i_data  = data;
      #1;
   endtask

   task automatic idle_in();
      bus.i_valid = 1'b0;
      bus.i_sop   = 1'b0;
      bus.i_eop   = 1'b0;
      bus.i_td    = 1'b0;
      bus.i_len   = '0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      d0 = {32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 32'hDDEE_FF00,
            32'h0F1E_2D3C, 32'h4B5A_6978, 32'h8796_A5B4, 32'hC3D2_E1F0};
      d1 = {8{32'hA5A5_0F0F}};
      d2 = {32'hDEAD_BEEF, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h1234_5678, 32'h9ABC_DEF0, 32'h0BAD_F00D, 32'hCAFE_BABE};
      d3 = {32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10,
            32'h1112_1314, 32'h1516_1718, 32'h191A_1B1C, 32'h1D1E_1F20};
      d4 = {32'h7E00_0000, 224'h0};
      rst_n = 1'b0;
      bus.i_ecrc_ready = 1'b0;
      bus.i_data = '0;
      idle_in();

      // reset state, with a SOP beat presented while in reset
      step();
      beat(1'b1, 1'b1, 1'b1, 4'd4, d0);
      chk("rst_crc_en", 64'(bus.o_crc_en), 64'd0);
      chk("rst_seed_load", 64'(bus.o_crc_seed_load), 64'd0);
      step();
      chk("rst_ready", 64'(bus.o_ready), 64'd1);
      chk("rst_valid", 64'(bus.o_ecrc_valid), 64'd0);
      chk("rst_ecrc", 64'(bus.o_ecrc), 64'd0);
      chk("rst_err", 64'(bus.o_err), 64'd0);
      idle_in();
      rst_n = 1'b1;
      step();

      // 1: single-beat TLP
      beat(1'b1, 1'b1, 1'b1, 4'd4, d0);
      chk("t1_seed_load", 64'(bus.o_crc_seed_load), 64'd1);
      chk("t1_seed", 64'(bus.o_crc_seed), 64'hFFFF_FFFF);
      chk("t1_en", 64'(bus.o_crc_en), 64'd1);
      chk("t1_len", 64'(bus.o_crc_len), 64'd4);
      chk("t1_msg_hi", 64'(bus.o_crc_msg[255:224]), 64'(sopmsg(d0) >> 224));
      e = crc_step(32'hFFFF_FFFF, sopmsg(d0), 4);
      step();
      idle_in();
      chk("t1_valid", 64'(bus.o_ecrc_valid), 64'd1);
      chk("t1_ready_low", 64'(bus.o_ready), 64'd0);
      chk("t1_ecrc", 64'(bus.o_ecrc), 64'(fin(e)));
      bus.i_ecrc_ready = 1'b1;
      step();
      bus.i_ecrc_ready = 1'b0;
      chk("t1_valid_drop", 64'(bus.o_ecrc_valid), 64'd0);
      chk("t1_ready_back", 64'(bus.o_ready), 64'd1);

      // 2: three beats, lens 8/8/3, back-pressured ECRC
      beat(1'b1, 1'b0, 1'b1, 4'd8, d1);
      e1 = crc_step(32'hFFFF_FFFF, sopmsg(d1), 8);
      step();
      beat(1'b0, 1'b0, 1'b0, 4'd8, d2);
      chk("t2_b2_load", 64'(bus.o_crc_seed_load), 64'd0);
      chk("t2_b2_seed", 64'(bus.o_crc_seed), 64'(e1));
      chk("t2_b2_en", 64'(bus.o_crc_en), 64'd1);
      e2 = crc_step(e1, d2, 8);
      step();
      beat(1'b0, 1'b1, 1'b1, 4'd3, d3);
      chk("t2_b3_seed", 64'(bus.o_crc_seed), 64'(e2));
      e = crc_step(e2, d3, 3);
      step();
      beat(1'b1, 1'b1, 1'b1, 4'd4, d4);
      for (int i = 0; i < 5; i++) begin
         chk("t2_hold_ready", 64'(bus.o_ready), 64'd0);
         chk("t2_hold_en", 64'(bus.o_crc_en), 64'd0);
         chk("t2_hold_valid", 64'(bus.o_ecrc_valid), 64'd1);
         chk("t2_hold_ecrc", 64'(bus.o_ecrc), 64'(fin(e)));
         step();
      end
      idle_in();
      bus.i_ecrc_ready = 1'b1;
      step();
      bus.i_ecrc_ready = 1'b0;
      chk("t2_done", 64'(bus.o_ecrc_valid), 64'd0);
      chk("t2_no_err", 64'(bus.o_err), 64'd0);

      // 3: td=0 TLP is passed through with no ECRC
      beat(1'b1, 1'b0, 1'b0, 4'd8, d1);
      chk("t3_b1_en", 64'(bus.o_crc_en), 64'd0);
      step();
      beat(1'b0, 1'b1, 1'b1, 4'd8, d2);
      chk("t3_b2_en", 64'(bus.o_crc_en), 64'd0);
      step();
      idle_in();
      chk("t3_valid", 64'(bus.o_ecrc_valid), 64'd0);
      chk("t3_ready", 64'(bus.o_ready), 64'd1);
      step();
      chk("t3_valid_later", 64'(bus.o_ecrc_valid), 64'd0);

      // 4a: non-SOP beat in IDLE
      beat(1'b0, 1'b0, 1'b1, 4'd4, d0);
      chk("t4_drop_en", 64'(bus.o_crc_en), 64'd0);
      step();
      idle_in();
      chk("t4_err", 64'(bus.o_err), 64'd1);
      step();
      chk("t4_err_pulse", 64'(bus.o_err), 64'd0);

      // 4b: SOP in ACCUM aborts the old TLP
      beat(1'b1, 1'b0, 1'b1, 4'd8, d1);
      step();
      beat(1'b1, 1'b0, 1'b1, 4'd4, d2);
      chk("t4_resop_load", 64'(bus.o_crc_seed_load), 64'd1);
      chk("t4_resop_seed", 64'(bus.o_crc_seed), 64'hFFFF_FFFF);
      e = crc_step(32'hFFFF_FFFF, sopmsg(d2), 4);
      step();
      chk("t4_abort_err", 64'(bus.o_err), 64'd1);
      chk("t4_abort_valid", 64'(bus.o_ecrc_valid), 64'd0);
      beat(1'b0, 1'b1, 1'b0, 4'd2, d3);
      e = crc_step(e, d3, 2);
      step();
      idle_in();
      chk("t4_new_valid", 64'(bus.o_ecrc_valid), 64'd1);
      chk("t4_new_ecrc", 64'(bus.o_ecrc), 64'(fin(e)));
      bus.i_ecrc_ready = 1'b1;
      step();
      bus.i_ecrc_ready = 1'b0;

      // 5: bad lengths mid-TLP are consumed without updating the CRC
      beat(1'b1, 1'b0, 1'b1, 4'd8, d0);
      e = crc_step(32'hFFFF_FFFF, sopmsg(d0), 8);
      step();
      beat(1'b0, 1'b0, 1'b1, 4'd0, d1);
      chk("t5_len0_en", 64'(bus.o_crc_en), 64'd0);
      step();
      chk("t5_len0_err", 64'(bus.o_err), 64'd1);
      beat(1'b0, 1'b0, 1'b1, 4'd9, d2);
      chk("t5_len9_en", 64'(bus.o_crc_en), 64'd0);
      step();
      chk("t5_len9_err", 64'(bus.o_err), 64'd1);
      beat(1'b0, 1'b1, 1'b1, 4'd5, d3);
      chk("t5_seed_kept", 64'(bus.o_crc_seed), 64'(e));
      e = crc_step(e, d3, 5);
      step();
      idle_in();
      chk("t5_err_clear", 64'(bus.o_err), 64'd0);
      chk("t5_ecrc", 64'(bus.o_ecrc), 64'(fin(e)));
      bus.i_ecrc_ready = 1'b1;
      step();
      bus.i_ecrc_ready = 1'b0;

      // 6: reset while an ECRC is pending
      beat(1'b1, 1'b1, 1'b1, 4'd1, d4);
      step();
      idle_in();
      chk("t6_valid", 64'(bus.o_ecrc_valid), 64'd1);
      rst_n = 1'b0;
      step();
      chk("t6_rst_valid", 64'(bus.o_ecrc_valid), 64'd0);
      chk("t6_rst_ready", 64'(bus.o_ready), 64'd1);
      rst_n = 1'b1;
      step();
      chk("t6_after_valid", 64'(bus.o_ecrc_valid), 64'd0);

`ifdef ECRC_VARIANT_MASK_EN
      // EP=0 and EP=1 headers must hash identically
      dm = d0;
      dm[238] = 1'b0;
      beat(1'b1, 1'b1, 1'b1, 4'd4, dm);
      step();
      idle_in();
      chk("vm_ep0", 64'(bus.o_ecrc), 64'(fin(crc_step(32'hFFFF_FFFF, sopmsg(d0), 4))));
      bus.i_ecrc_ready = 1'b1;
      step();
      bus.i_ecrc_ready = 1'b0;
      dm[238] = 1'b1;
      beat(1'b1, 1'b1, 1'b1, 4'd4, dm);
      step();
      idle_in();
      chk("vm_ep1", 64'(bus.o_ecrc), 64'(fin(crc_step(32'hFFFF_FFFF, sopmsg(d0), 4))));
      bus.i_ecrc_ready = 1'b1;
      step();
      bus.i_ecrc_ready = 1'b0;
`else
      dm = '0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
